// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART serial transmitter paced by an external baud tick
module uart_tx #(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 txd,
    output logic                 busy,
    output logic                 tx_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP
    } state_t;

    localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

    state_t                 state_q, state_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   par_q, par_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic                   stop_cnt_q, stop_cnt_d;
    logic                   txd_q, txd_d;
    logic                   tx_ready_q, tx_ready_d;
    logic                   busy_q, busy_d;
    logic                   tx_done_q, tx_done_d;
    logic                   xfer;

    // A byte is taken only while idle and advertising ready.
    assign xfer = (state_q == S_IDLE) & tx_valid & tx_ready_q;

    // Next-state logic: every bit boundary after acceptance waits for a baud tick.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        par_d      = par_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        txd_d      = txd_q;
        tx_ready_d = tx_ready_q;
        busy_d     = busy_q;
        tx_done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                txd_d      = 1'b1;
                tx_ready_d = 1'b1;
                busy_d     = 1'b0;
                if (xfer) begin
                    shift_d    = tx_data;
                    par_d      = (PARITY == 1) ? ~^tx_data : ^tx_data;
                    tx_ready_d = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = S_SYNC;
                end
            end
            S_SYNC: begin
                // The tick of the acceptance cycle was seen in IDLE, so the
                // start bit always begins on a fresh tick and lasts a full period.
                if (baud_tick) begin
                    txd_d   = 1'b0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (baud_tick) begin
                    txd_d     = shift_q[0];
                    bit_cnt_d = 3'd0;
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                if (baud_tick) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        if (PARITY != 0) begin
                            txd_d   = par_q;
                            state_d = S_PAR;
                        end else begin
                            txd_d      = 1'b1;
                            stop_cnt_d = 1'b0;
                            state_d    = S_STOP;
                        end
                    end else begin
                        // Shifting keeps the next data bit at index 1.
                        txd_d     = shift_q[1];
                        shift_d   = shift_q >> 1;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            S_PAR: begin
                if (baud_tick) begin
                    txd_d      = 1'b1;
                    stop_cnt_d = 1'b0;
                    state_d    = S_STOP;
                end
            end
            S_STOP: begin
                if (baud_tick) begin
                    if (stop_cnt_q == LAST_STOP) begin
                        tx_done_d  = 1'b1;
                        busy_d     = 1'b0;
                        tx_ready_d = 1'b1;
                        state_d    = S_IDLE;
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                txd_d   = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    // State register; reset aborts any frame and returns the line to mark.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            shift_q    <= '0;
            par_q      <= 1'b0;
            bit_cnt_q  <= 3'd0;
            stop_cnt_q <= 1'b0;
            txd_q      <= 1'b1;
            tx_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            tx_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            txd_q      <= txd_d;
            tx_ready_q <= tx_ready_d;
            busy_q     <= busy_d;
            tx_done_q  <= tx_done_d;
        end
    end

    assign txd      = txd_q;
    assign tx_ready = tx_ready_q;
    assign busy     = busy_q;
    assign tx_done  = tx_done_q;

endmodule
